// File: rtl/noc_pkg.sv
// noc_pkg: shared router constants, flit encoding and allocator state types.
package noc_pkg;
    localparam int NPORT = 5;
    localparam int P_L = 0;
    localparam int P_N = 1;
    localparam int P_E = 2;
    localparam int P_S = 3;
    localparam int P_W = 4;
    localparam int CREDITS = 4;
    localparam int CW = $clog2(CREDITS + 1);
    localparam int FLIT_W = 40;
    localparam int FLIT_TYPE_MSB = 39;
    localparam int FLIT_TYPE_LSB = 38;
    localparam int FLIT_DST_MSB = 37;
    localparam int FLIT_DST_LSB = 32;
    localparam int FLIT_DATA_MSB = 31;
    localparam int FLIT_DATA_LSB = 0;
    typedef enum logic [1:0] {FT_SINGLE = 2'b00, FT_HEAD = 2'b01, FT_BODY = 2'b10, FT_TAIL = 2'b11} flit_type_e;
    typedef enum logic {S_IDLE, S_LOCKED} alloc_state_e;
    function automatic logic [2:0] next_port(input logic [2:0] p);
        return (p == 3'(NPORT - 1)) ? 3'd0 : p + 3'd1;
    endfunction
endpackage

// File: rtl/sa_port_allocator_if.sv
// sa_port_allocator_if: request/grant and credit signals of one output-port allocator.
interface sa_port_allocator_if;
    logic [noc_pkg::NPORT-1:0] req;
    logic [noc_pkg::NPORT-1:0] is_tail;
    logic                      out_full;
    logic                      credit_ret;
    logic [noc_pkg::NPORT-1:0] grant;
    logic                      winc;
    logic                      locked;
    logic [2:0]                owner;
    logic [noc_pkg::CW-1:0]    credit_cnt;
    logic                      credit_err;
    modport master (output req, is_tail, out_full, credit_ret,
                    input grant, winc, locked, owner, credit_cnt, credit_err);
    modport slave (input req, is_tail, out_full, credit_ret,
                   output grant, winc, locked, owner, credit_cnt, credit_err);
endinterface

// File: rtl/rr_pick.sv
// rr_pick: picks the first set request scanning cyclically upward from ptr_i.
module rr_pick
    import noc_pkg::*;
(
    input  logic [NPORT-1:0] req_i,
    input  logic [2:0]       ptr_i,
    output logic [NPORT-1:0] win_o,
    output logic [2:0]       idx_o
);
    // Scan from the farthest slot back towards ptr so the nearest request wins last.
    always_comb begin
        win_o = '0;
        idx_o = '0;
        for (int k = NPORT - 1; k >= 0; k--) begin
            int j;
            j = (int'(ptr_i) + k) % NPORT;
            if (req_i[j]) begin
                win_o = '0;
                win_o[j] = 1'b1;
                idx_o = 3'(j);
            end
        end
    end
endmodule

// File: rtl/sa_port_allocator.sv
// sa_port_allocator: round-robin output-port allocator with packet locking
// and downstream credit tracking; grant is combinational from the current state.
module sa_port_allocator
    import noc_pkg::*;
(
    input logic               clk,
    input logic               rst,
    sa_port_allocator_if.slave p
);
    alloc_state_e   state_q, state_d;
    logic [2:0]     ptr_q, ptr_d, owner_q, owner_d, rr_idx, w;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           err_q, err_d, ok, xfer, tail;
    logic [NPORT-1:0] rr_win, lock_grant;
    rr_pick u_pick (.req_i(p.req), .ptr_i(ptr_q), .win_o(rr_win), .idx_o(rr_idx));
    assign ok = (cnt_q != '0) && !p.out_full && !rst;
    assign lock_grant = {{(NPORT-1){1'b0}}, p.req[owner_q]} << owner_q;
    assign p.grant = !ok ? '0 : (state_q == S_LOCKED) ? lock_grant : rr_win;
    assign xfer = |p.grant;
    assign w = (state_q == S_LOCKED) ? owner_q : rr_idx;
    assign tail = p.is_tail[w];
    assign p.winc = xfer;
    assign p.locked = (state_q == S_LOCKED) && !rst;
    assign p.owner = owner_q;
    assign p.credit_cnt = cnt_q;
    assign p.credit_err = err_q;
    always_comb begin
        state_d = xfer ? (tail ? S_IDLE : S_LOCKED) : state_q;
        ptr_d = (xfer && tail) ? next_port(w) : ptr_q;
        owner_d = (xfer && !tail) ? w : owner_q;
        // A return at full count with no transfer saturates and flags the upstream bug.
        cnt_d = (xfer && !p.credit_ret) ? cnt_q - CW'(1)
              : (!xfer && p.credit_ret && cnt_q != CW'(CREDITS)) ? cnt_q + CW'(1) : cnt_q;
        err_d = err_q | (p.credit_ret && !xfer && cnt_q == CW'(CREDITS));
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q <= '0;
            owner_q <= '0;
            cnt_q <= CW'(CREDITS);
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q <= ptr_d;
            owner_q <= owner_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
endmodule

// File: doc/sa_port_allocator.md
# sa_port_allocator

Per-output-port switch allocator for the 5-port packet-switching router. One instance sits in front of each output port (L, N, E, S, W). It takes routed head-of-queue requests from all five input ports and grants the port to one of them with round-robin fairness. It holds the grant for multi-flit packets until the tail flit, and tracks downstream buffer space with a credit counter. Its one-hot grant drives the port's crossbar select (`*_arb_res`) and output FIFO write enable.

## Interface
- `NPORT`, 5: number of requesting input ports; index order L=0, N=1, E=2, S=3, W=4.
- `CREDITS`, 4: downstream buffer slots; equals router FIFO `DEPTH`.
- `CW`, $clog2(CREDITS+1): credit counter width.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  NPORT  input i has a valid head-of-queue flit whose label selects this output.
- `is_tail`  in  NPORT  flit at input i is TAIL or SINGLE type (meaningful only when `req[i]`).
- `out_full`  in  1  downstream/output FIFO full; blocks all grants.
- `credit_ret`  in  1  one downstream slot freed this cycle (at most one per cycle).
- `grant`  out  NPORT  one-hot transfer grant; the granted input dequeues at this edge.
- `winc`  out  1  output FIFO write enable; equals `|grant`.
- `locked`  out  1  allocator is in LOCKED state.
- `owner`  out  3  index of the locked input; valid only while `locked` is high.
- `credit_cnt`  out  CW  current credits.
- `credit_err`  out  1  sticky flag; a credit was returned while the counter was at `CREDITS`.

## Operation
- Transfer condition: `xfer = |grant`. `grant` is asserted only if `credit_cnt != 0`, `!out_full`, and `!rst`.
- FSM states: IDLE and LOCKED.
- IDLE:
  - `grant` goes to the first `req[i]` found scanning cyclically from `ptr`.
  - On a transfer with `is_tail[w]` set: stay IDLE; `ptr <= (w+1) mod NPORT`.
  - On a transfer without tail: go to LOCKED; `owner <= w`; `ptr` is unchanged.
- LOCKED:
  - Only `owner` is eligible, so `grant[owner] = req[owner]` gated by credits and `!out_full`.
  - All other requests are ignored, even when `owner` has no request.
  - On transfer of a flit with `is_tail[owner]` set: go to IDLE; `ptr <= (owner+1) mod NPORT`.
- Credits:
  - `credit_cnt` decrements on `xfer` and increments on `credit_ret`.
  - Both in the same cycle: counter unchanged.
  - `credit_ret` when `credit_cnt == CREDITS` and no `xfer`: counter saturates and `credit_err <= 1`.
- Pointer wrap: `ptr` is 0..NPORT-1; after index 4 it wraps to 0.
- Reset values: state IDLE, `ptr` 0, `owner` 0, `credit_cnt` CREDITS, `credit_err` 0.
- While `rst` is high, `grant` = 0, `winc` = 0, `locked` = 0.
- Reset mid-packet drops the lock unconditionally. Upstream must flush.

## Timing
- Request-to-grant is combinational, zero cycles (Mealy): `grant` is a function of `req`, `is_tail`, `out_full`, `credit_cnt`, state, `ptr`, `owner`.
- The requester sees `grant` in the same cycle and pops its FIFO on that rising edge. The next flit's `req` is evaluated in the following cycle.
- There is no credit bypass. A `credit_ret` at cycle t is usable at t+1. When `credit_cnt == 0`, `grant` is 0 regardless of `credit_ret`.
- Peak throughput is one flit per cycle per output.
- There is no combinational path from `credit_ret` to `grant`.

## Structure
- Shared package `noc_pkg` holds:
  - Port index constants (`P_L`=0, `P_N`=1, `P_E`=2, `P_S`=3, `P_W`=4) and `NPORT`.
  - Flit type encoding: SINGLE=2'b00, HEAD=2'b01, BODY=2'b10, TAIL=2'b11.
  - Flit field offsets for the 40-bit flit.
  - The allocator FSM state enum.
- One sub-module, `rr_pick`: combinational cyclic priority picker. Inputs are `req[NPORT]` and `ptr`; outputs are a one-hot winner and its index. The selection logic lives only there.
- The top module holds the FSM, pointer, owner and credit registers.

## Test plan
- **Reset:** hold `rst`=1 with `req`=5'b11111 → `grant`=0. Release → `credit_cnt`=4, `ptr`=0, so the first grant is 5'b00001.
- **Round-robin:** `req`=5'b11111 with all `is_tail`=1 for 6 cycles → `grant` sequence 00001, 00010, 00100, 01000, 10000, 00001, with `credit_ret`=1 every cycle from cycle 1.
- **Packet lock:**
  - N sends HEAD, then E requests.
  - N's BODY request is absent for 2 cycles → `grant`=0 (E is blocked) and `locked`=1, `owner`=1.
  - N's TAIL is granted → next cycle `locked`=0 and E is granted (00100).
- **Credits:** with no `credit_ret`, 4 single-flit transfers → `credit_cnt`=0 and `grant`=0 on the 5th request. Pulse `credit_ret` → grant resumes the cycle after.
- **Simultaneous events:** `xfer` and `credit_ret` in the same cycle at `credit_cnt`=2 → stays 2.
- **Overflow and full:**
  - `credit_ret` at 4 → `credit_cnt` stays 4 and `credit_err`=1 (sticky until reset).
  - `out_full`=1 with active `req` → `grant`=0 and `ptr` unchanged.
